// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the sequential add-and-shift multiplier:
// controller state encoding and the counter-width helper.
package shift_add_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Smallest bit count able to hold values 0..value-1 (ceil(log2(value))).
    function automatic int clog2_f(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/shift_add_mult_dp.sv
// Multiplier datapath: multiplicand A, partial-product accumulator ACC
// (one guard bit wider than the operands) and multiplier Q, plus the
// add/subtract and the combined right shift of {ACC,Q}.
module shift_add_mult_dp #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,      // capture operands, clear ACC
    input  logic                 step_i,      // perform one iteration
    input  logic                 mode_i,      // 1: two's complement operands
    input  logic                 sub_i,       // subtract (signed multiplier MSB)
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   prod_next_o  // {ACC,Q} as it will be after this edge
);

    logic [WIDTH-1:0] a_q,   a_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q,   q_d;
    logic [WIDTH:0]   addend;
    logic [WIDTH+1:0] sum_ext;   // one extra bit captures the unsigned carry
    logic             shift_in;

    // Iteration arithmetic and next-state selection for A/ACC/Q.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        addend   = '0;
        a_d      = a_q;
        acc_d    = acc_q;
        q_d      = q_q;

        if (q_q[0]) begin
            addend = {mode_i & a_q[WIDTH-1], a_q};
        end

        if (sub_i) begin
            sum_ext = {1'b0, acc_q} - {1'b0, addend};
        end else begin
            sum_ext = {1'b0, acc_q} + {1'b0, addend};
        end

        // Signed: replicate the sign of the WIDTH+1 bit sum. Unsigned: carry-out.
        shift_in = mode_i ? sum_ext[WIDTH] : sum_ext[WIDTH+1];

        if (load_i) begin
            a_d   = a_i;
            q_d   = b_i;
            acc_d = '0;
        end else if (step_i) begin
            acc_d = {shift_in, sum_ext[WIDTH:1]};
            q_d   = {sum_ext[0], q_q[WIDTH-1:1]};
        end

        prod_next_o = {acc_d[WIDTH-1:0], q_d};
    end

    // Operand and partial-product registers.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset too, so an aborted operation leaves no stale operands behind.
        if (reset) begin
            a_q   <= '0;
            acc_q <= '0;
            q_q   <= '0;
        end else begin
            a_q   <= a_d;
            acc_q <= acc_d;
            q_q   <= q_d;
        end
    end

endmodule

// File: rtl/shift_add_mult.sv
// Parametrised sequential add-and-shift multiplier, signed or unsigned per
// operation. start/busy/done handshake, fixed WIDTH iterations, result held
// in a register until the next accepted request completes.
module shift_add_mult
    import shift_add_mult_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = clog2_f(WIDTH + 1);

    state_t               state_q;
    logic [CNT_W-1:0]     count_q;
    logic                 mode_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   product_q;

    logic                 load;
    logic                 step;
    logic                 last_iter;
    logic                 sub;
    logic [2*WIDTH-1:0]   prod_next;

    assign load      = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign step      = (state_q == ST_CALC);
    assign last_iter = step && (count_q == CNT_W'(WIDTH - 1));
    assign sub       = mode_q && last_iter;

    shift_add_mult_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load),
        .step_i      (step),
        .mode_i      (mode_q),
        .sub_i       (sub),
        .a_i         (a),
        .b_i         (b),
        .prod_next_o (prod_next)
    );

    // Controller: accept requests, count iterations, publish the result.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            mode_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (load) begin
                        count_q <= '0;
                        mode_q  <= is_signed & SIGNED_EN;
                        busy_q  <= 1'b1;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    count_q <= count_q + CNT_W'(1);
                    if (last_iter) begin
                        product_q <= prod_next;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
